// File: rtl/seq_stream_checker_pkg.sv
// Shared types and sizing helpers for the incrementing-stream checker.
package seq_stream_checker_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_t;

  // Run counters must hold whichever of the lock/loss thresholds is larger.
  function automatic int unsigned run_width(input int unsigned lock_cnt,
                                            input int unsigned loss_cnt);
    int unsigned m;
    m = (lock_cnt > loss_cnt) ? lock_cnt : loss_cnt;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_stream_checker_sat_counter.sv
// Saturating up-counter; a clear coincident with an increment leaves the count at 1.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_stream_checker.sv
// Sink-side checker for the +1 addr/data counter stream: locks, counts and records mismatches.
module seq_stream_checker
  import seq_stream_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned LOSS_CNT   = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  clr_stats,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  first_err_valid
);

  localparam int unsigned RW = run_width(LOCK_CNT, LOSS_CNT);
  localparam logic [RW-1:0] LOCK_TGT = RW'(LOCK_CNT);
  localparam logic [RW-1:0] LOSS_TGT = RW'(LOSS_CNT);

  chk_state_t            state;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [RW-1:0]         match_run;
  logic [RW-1:0]         miss_run;

  logic          beat;
  logic          match;
  logic          err;
  logic [RW-1:0] match_run_nxt;
  logic [RW-1:0] miss_run_nxt;

  always_comb begin
    beat          = in_valid & in_ready;
    match         = (in_addr == exp_addr) && (in_data == exp_data);
    err           = beat && (state == ST_LOCKED) && !match;
    match_run_nxt = match_run + RW'(1);
    miss_run_nxt  = miss_run + RW'(1);
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .inc  (err),
    .clr  (clr_stats),
    .count(err_cnt)
  );

  // Statistics: a clear takes effect before the coincident beat's contribution.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_ready        <= 1'b0;
      err_pulse       <= 1'b0;
      word_cnt        <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else begin
      in_ready  <= !clr_stats;
      err_pulse <= err;
      word_cnt  <= (clr_stats ? '0 : word_cnt) + CNT_WIDTH'(beat);
      if (err && (clr_stats || !first_err_valid)) begin
        first_err_addr  <= in_addr;
        first_err_valid <= 1'b1;
      end else if (clr_stats) begin
        first_err_addr  <= '0;
        first_err_valid <= 1'b0;
      end
    end
  end

  // match_run == 0 in SEARCH marks "no seed yet", so the next beat always reseeds.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_SEARCH;
      locked    <= 1'b0;
      exp_addr  <= '0;
      exp_data  <= '0;
      match_run <= '0;
      miss_run  <= '0;
    end else if (beat) begin
      case (state)
        ST_SEARCH: begin
          exp_addr <= in_addr + ADDR_WIDTH'(1);
          exp_data <= in_data + DATA_WIDTH'(1);
          if ((match_run != '0) && match) begin
            match_run <= match_run_nxt;
            if (match_run_nxt == LOCK_TGT) begin
              state    <= ST_LOCKED;
              locked   <= 1'b1;
              miss_run <= '0;
            end
          end else begin
            match_run <= RW'(1);
          end
        end
        ST_LOCKED: begin
          exp_addr <= exp_addr + ADDR_WIDTH'(1);
          exp_data <= exp_data + DATA_WIDTH'(1);
          if (match) begin
            miss_run <= '0;
          end else begin
            miss_run <= miss_run_nxt;
            if (miss_run_nxt == LOSS_TGT) begin
              state     <= ST_SEARCH;
              locked    <= 1'b0;
              match_run <= '0;
            end
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stream_checker.sv
// Scoreboard bench for seq_stream_checker: a behavioural model predicts outputs per accepted beat.
module tb_seq_stream_checker;

  localparam int unsigned LOCK = 4;
  localparam int unsigned LOSS = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        clr_stats = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [15:0] word_cnt;
  logic [31:0] first_err_addr;
  logic        first_err_valid;

  seq_stream_checker #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .LOCK_CNT  (LOCK),
    .LOSS_CNT  (LOSS),
    .CNT_WIDTH (16)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .clr_stats      (clr_stats),
    .locked         (locked),
    .err_pulse      (err_pulse),
    .err_cnt        (err_cnt),
    .word_cnt       (word_cnt),
    .first_err_addr (first_err_addr),
    .first_err_valid(first_err_valid)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [15:0] word_cnt;
    logic [31:0] fea;
    logic        fev;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit          m_locked, m_seeded;
  int unsigned m_mrun, m_xrun;
  logic [31:0] m_exp_a, m_exp_d, m_fea;
  logic [15:0] m_err, m_word;
  bit          m_fev;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_seeded = 0; m_mrun = 0; m_xrun = 0;
    m_exp_a = '0; m_exp_d = '0; m_fea = '0; m_err = '0; m_word = '0; m_fev = 0;
  endtask

  task automatic model_clear();
    m_err = '0; m_word = '0; m_fea = '0; m_fev = 0;
  endtask

  task automatic model_beat(input logic [31:0] a, input logic [31:0] d, input bit clr);
    bit   m, e;
    exp_t x;
    m = (a == m_exp_a) && (d == m_exp_d);
    e = m_locked && !m;
    if (clr) model_clear();
    m_word = m_word + 16'd1;
    if (e) begin
      if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
      if (!m_fev) begin m_fev = 1; m_fea = a; end
    end
    if (!m_locked) begin
      if (m_seeded && m) begin
        m_mrun++;
        if (m_mrun == LOCK) begin m_locked = 1; m_xrun = 0; end
      end else begin
        m_seeded = 1; m_mrun = 1;
      end
      m_exp_a = a + 32'd1;
      m_exp_d = d + 32'd1;
    end else begin
      m_exp_a = m_exp_a + 32'd1;
      m_exp_d = m_exp_d + 32'd1;
      if (m) m_xrun = 0;
      else begin
        m_xrun++;
        if (m_xrun == LOSS) begin m_locked = 0; m_seeded = 0; end
      end
    end
    x.locked = m_locked; x.err_pulse = e; x.err_cnt = m_err;
    x.word_cnt = m_word; x.fea = m_fea; x.fev = m_fev;
    exp_q.push_back(x);
  endtask

  task automatic compare_head();
    exp_t x;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
      return;
    end
    x = exp_q.pop_front();
    check_val("locked", locked, x.locked);
    check_val("err_pulse", err_pulse, x.err_pulse);
    check_val("err_cnt", err_cnt, x.err_cnt);
    check_val("word_cnt", word_cnt, x.word_cnt);
    check_val("first_err_addr", first_err_addr, x.fea);
    check_val("first_err_valid", first_err_valid, x.fev);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input bit clr);
    int unsigned waited;
    waited = 0;
    @(negedge sys_clk);
    while (!in_ready && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    if (!in_ready) begin
      check_val("ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1; in_addr = a; in_data = d; clr_stats = clr;
    model_beat(a, d, clr);
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0; clr_stats = 1'b0;
    compare_head();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, in_ready, 0);
    check_val({tag, "_locked"}, locked, 0);
    check_val({tag, "_pulse"}, err_pulse, 0);
    check_val({tag, "_errcnt"}, err_cnt, 0);
    check_val({tag, "_wordcnt"}, word_cnt, 0);
    check_val({tag, "_fea"}, first_err_addr, 0);
    check_val({tag, "_fev"}, first_err_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check_all_zero("rst");
    model_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all_zero("por");
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    // T1: lock on 0..9
    for (int i = 0; i < 10; i++) begin
      send(i, i, 0);
      if (i == 2) check_val("t1_not_locked_b2", locked, 0);
      if (i == 3) check_val("t1_locked_b3", locked, 1);
    end
    check_val("t1_word", word_cnt, 10);
    check_val("t1_err", err_cnt, 0);

    // T2: single corrupt word at addr 20
    for (int i = 10; i < 20; i++) send(i, i, 0);
    send(20, 32'hDEAD, 0);
    check_val("t2_pulse", err_pulse, 1);
    check_val("t2_err", err_cnt, 1);
    check_val("t2_fea", first_err_addr, 20);
    send(21, 21, 0);
    check_val("t2_pulse_drop", err_pulse, 0);
    check_val("t2_locked", locked, 1);

    // Clear without a beat
    @(negedge sys_clk);
    clr_stats = 1'b1;
    model_clear();
    @(posedge sys_clk);
    #1;
    clr_stats = 1'b0;
    check_val("clr_ready", in_ready, 0);
    check_val("clr_err", err_cnt, 0);
    check_val("clr_word", word_cnt, 0);
    check_val("clr_fev", first_err_valid, 0);

    // T3: three corrupt beats drop lock, four clean beats re-lock
    for (int i = 22; i < 25; i++) send(i, i ^ 32'hFFFF, 0);
    check_val("t3_err", err_cnt, 3);
    check_val("t3_unlocked", locked, 0);
    check_val("t3_fea", first_err_addr, 22);
    for (int i = 25; i < 29; i++) send(i, i, 0);
    check_val("t3_relock", locked, 1);

    // T4: lock across the 32-bit wrap
    do_reset();
    begin
      logic [31:0] v;
      v = 32'hFFFF_FFFD;
      for (int i = 0; i < 6; i++) begin
        send(v, v, 0);
        v = v + 32'd1;
      end
    end
    check_val("t4_locked", locked, 1);
    check_val("t4_err", err_cnt, 0);

    // T5: clear coincident with a corrupt locked beat
    send(3, 32'h0BAD, 1);
    check_val("t5_err", err_cnt, 1);
    check_val("t5_word", word_cnt, 1);
    check_val("t5_fea", first_err_addr, 3);
    check_val("t5_ready", in_ready, 0);
    send(4, 4, 0);

    // T6: asynchronous reset mid-stream
    for (int i = 100; i < 106; i++) send(i, i, 0);
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    model_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 200; i < 204; i++) begin
      send(i, i, 0);
      if (i < 203) check_val("t6_not_locked", locked, 0);
    end
    check_val("t6_relock", locked, 1);

    check_val("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
